prng_access_arbiter: RTL and testbench

- Sequences and shares the 64-bit PCG generator (two 32-bit PCG lanes plus seed generator) between NREQ consumers.
- Drives the core's reset and seedloop and runs the reseed sequence: hold reset, then warm up, then serve.
- Hands out each generated 64-bit word to at most one requester, using round-robin arbitration with one grant per cycle.

---
 rtl/prng_access_arbiter.sv | 171 +++++++++++++++++
 tb/tb_prng_access_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_access_arbiter.sv
// prng_access_arbiter: sequences the PCG core through reset and warm-up,
// then hands each core word to one requester per cycle, round-robin.
module prng_access_arbiter #(
   parameter int unsigned NREQ          = 4,
   parameter int unsigned RST_CYCLES    = 2,
   parameter int unsigned WARMUP_CYCLES = 8,
   parameter logic [63:0] SEED_DEFAULT  = 64'h0123_4567_89AB_CDEF,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      seed_in,
   input  logic             reseed_req,
   output logic             reseed_busy,
   output logic             core_rst,
   output logic [63:0]      core_seedloop,
   input  logic [63:0]      core_random,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  grant,
   output logic [63:0]      rnd_data,
   output logic             rnd_valid,
   output logic [CNT_W-1:0] served_count
);

   localparam int unsigned PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PH_MAX =
      (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
   localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
   localparam logic [PH_W-1:0] WU_LAST  = PH_W'(WARMUP_CYCLES - 1);

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      WARMUP = 2'd1,
      SERVE  = 2'd2
   } state_t;

   state_t            state;
   state_t            st_nxt;
   logic [PH_W-1:0]   ph;
   logic [PH_W-1:0]   ph_nxt;

   logic              core_rst_nxt;
   logic              busy_nxt;
   logic              grant_en;

   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  ptr_nxt;
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [PTR_W:0]    off;
   logic [PTR_W:0]    idx_sum;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_vld;
   logic [NREQ-1:0]   pick_oh;

   // Phase state register: current sequence state and its cycle counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HOLD;
         ph    <= '0;
      end else begin
         state <= st_nxt;
         ph    <= ph_nxt;
      end
   end

   // Next-state: hold -> warm-up -> serve; a reseed restarts from hold
   always_comb begin
      st_nxt = state;
      ph_nxt = ph + 1'b1;
      if (reseed_req) begin
         st_nxt = HOLD;
         ph_nxt = '0;
      end else begin
         unique case (state)
            HOLD: begin
               if (ph == RST_LAST) begin
                  st_nxt = WARMUP;
                  ph_nxt = '0;
               end
            end
            WARMUP: begin
               if (ph == WU_LAST) begin
                  st_nxt = SERVE;
                  ph_nxt = '0;
               end
            end
            SERVE: ph_nxt = '0;
            default: begin
               st_nxt = HOLD;
               ph_nxt = '0;
            end
         endcase
      end
   end

   // Output decode: registered core controls follow the next state
   always_comb begin
      core_rst_nxt = 1'b1;
      busy_nxt     = 1'b1;
      unique case (1'b1)
         (st_nxt == HOLD): begin
            core_rst_nxt = 1'b1;
            busy_nxt     = 1'b1;
         end
         (st_nxt == WARMUP): begin
            core_rst_nxt = 1'b0;
            busy_nxt     = 1'b1;
         end
         (st_nxt == SERVE): begin
            core_rst_nxt = 1'b0;
            busy_nxt     = 1'b0;
         end
         default: ;
      endcase
      grant_en = (state == SERVE) && pick_vld && !reseed_req;
   end

   // Round-robin pick: rotate req so rr_ptr is bit 0, take lowest set bit
   always_comb begin
      req_dbl  = {req, req};
      req_rot  = NREQ'(req_dbl >> rr_ptr);
      pick_vld = |req;
      off      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) off = (PTR_W + 1)'(k);
      end
      idx_sum = {1'b0, rr_ptr} + off;
      if (idx_sum >= (PTR_W + 1)'(NREQ))
         pick_idx = PTR_W'(idx_sum - (PTR_W + 1)'(NREQ));
      else
         pick_idx = PTR_W'(idx_sum);
      ptr_nxt = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      pick_oh = {{(NREQ - 1){1'b0}}, 1'b1} << pick_idx;
   end

   // Core control registers; seed latches on every reseed request
   always_ff @(posedge clk) begin
      if (rst) begin
         core_rst      <= 1'b1;
         core_seedloop <= SEED_DEFAULT;
         reseed_busy   <= 1'b1;
      end else begin
         core_rst    <= core_rst_nxt;
         reseed_busy <= busy_nxt;
         if (reseed_req) core_seedloop <= seed_in;
      end
   end

   // Grant pipeline: one word per cycle, pointer and count move on grant
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr       <= '0;
         served_count <= '0;
         grant        <= '0;
         rnd_valid    <= 1'b0;
         rnd_data     <= '0;
      end else begin
         rnd_valid <= grant_en;
         grant     <= grant_en ? pick_oh : '0;
         if (grant_en) begin
            rnd_data     <= core_random;
            rr_ptr       <= ptr_nxt;
            served_count <= served_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prng_access_arbiter.sv
// tb_prng_access_arbiter: directed and randomized stimulus against a
// cycle-level reference model of the arbiter's observable behaviour.
module tb_prng_access_arbiter;

   localparam int N  = 4;
   localparam int RC = 2;
   localparam int WC = 8;
   localparam logic [63:0] SD = 64'h0123_4567_89AB_CDEF;

   logic        clk;
   logic        rst;
   logic [63:0] seed_in;
   logic        reseed_req;
   logic        reseed_busy;
   logic        core_rst;
   logic [63:0] core_seedloop;
   logic [63:0] core_random;
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic [63:0] rnd_data;
   logic        rnd_valid;
   logic [31:0] served_count;

   int checks   = 0;
   int failures = 0;

   // model: age = cycles since the current (re)seed sequence started
   int          m_age;
   int          m_ptr;
   logic [63:0] m_seed;
   logic [63:0] m_data;
   logic [31:0] m_cnt;
   logic [N-1:0] m_grant;
   logic        m_valid;

   prng_access_arbiter #(
      .NREQ(N), .RST_CYCLES(RC), .WARMUP_CYCLES(WC),
      .SEED_DEFAULT(SD), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .seed_in(seed_in),
      .reseed_req(reseed_req), .reseed_busy(reseed_busy),
      .core_rst(core_rst), .core_seedloop(core_seedloop),
      .core_random(core_random), .req(req), .grant(grant),
      .rnd_data(rnd_data), .rnd_valid(rnd_valid),
      .served_count(served_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance the model by one clock edge using the inputs now applied
   task automatic model_edge();
      int pick;
      if (rst) begin
         m_age = 0; m_ptr = 0; m_seed = SD; m_data = '0;
         m_cnt = '0; m_grant = '0; m_valid = 1'b0;
      end else if (reseed_req) begin
         m_age = 0; m_seed = seed_in;
         m_grant = '0; m_valid = 1'b0;
      end else begin
         m_grant = '0;
         m_valid = 1'b0;
         if (m_age >= RC + WC && req != '0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
               if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            m_grant = N'(1) << pick;
            m_valid = 1'b1;
            m_data  = core_random;
            m_ptr   = (pick + 1) % N;
            m_cnt   = m_cnt + 1;
         end
         if (m_age < RC + WC) m_age++;
      end
   endtask

   task automatic check_all();
      chk("grant", grant, m_grant);
      chk("rnd_valid", rnd_valid, m_valid);
      chk("rnd_data", rnd_data, m_data);
      chk("core_rst", core_rst, (m_age < RC) ? 1'b1 : 1'b0);
      chk("reseed_busy", reseed_busy, (m_age < RC + WC) ? 1'b1 : 1'b0);
      chk("core_seedloop", core_seedloop, m_seed);
      chk("served_count", served_count, m_cnt);
   endtask

   task automatic step();
      core_random = {$urandom, $urandom};
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int first, rh, bc, g0, dup, resume;
      logic [N-1:0] first_g;
      logic [31:0] saved;
      logic [63:0] seed_b;
      logic [63:0] d [8];

      rst = 1'b1; req = '0; reseed_req = 1'b0;
      seed_in = '0; core_random = '0;
      repeat (3) step();

      // startup: req 0 held from release
      rst = 1'b0;
      req = 4'b0001;
      first = -1;
      rh = core_rst ? 1 : 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (core_rst) rh++;
         if (first < 0 && grant[0]) first = c;
      end
      chk("first_grant_cycle", 64'(first), 64'd11);
      chk("core_rst_cycles", 64'(rh), 64'd2);

      // all requesters: rotating grants, distinct words
      req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         step();
         d[c] = rnd_data;
      end
      dup = 0;
      for (int i = 0; i < 8; i++)
         for (int j = i + 1; j < 8; j++)
            if (d[i] == d[j]) dup++;
      chk("distinct8", 64'(dup), 64'd0);

      // pointer at 1 with req 0101; requester 0 takes a single word
      req = 4'b0001;
      step();
      req = 4'b0101;
      g0 = 0;
      first_g = '0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (c == 0) first_g = grant;
         if (grant[0]) begin
            g0++;
            req[0] = 1'b0;
         end
      end
      chk("rr_first_grant", 64'(first_g), 64'(4'b0100));
      chk("req0_single_grant", 64'(g0), 64'd1);

      // reseed while serving
      req = 4'b0010;
      repeat (3) step();
      saved = served_count;
      seed_in = 64'hDEAD_BEEF_0000_0001;
      reseed_req = 1'b1;
      step();
      reseed_req = 1'b0;
      chk("reseed_cancel", 64'(grant), 64'd0);
      chk("reseed_seed", core_seedloop, 64'hDEAD_BEEF_0000_0001);
      chk("reseed_cnt_kept", 64'(served_count), 64'(saved));
      bc = 1;
      rh = 1;
      resume = -1;
      for (int c = 1; c <= 30; c++) begin
         step();
         if (grant != '0) begin
            resume = c;
            break;
         end
         if (reseed_busy) bc++;
         if (core_rst) rh++;
      end
      chk("reseed_busy_cycles", 64'(bc), 64'd10);
      chk("reseed_rst_cycles", 64'(rh), 64'd2);
      chk("reseed_resume", 64'(resume), 64'd11);

      // reseed in the middle of warm-up restarts with the newest seed
      req = '0;
      seed_in = {$urandom, $urandom};
      reseed_req = 1'b1;
      step();
      reseed_req = 1'b0;
      repeat (6) step();
      seed_b = {$urandom, $urandom};
      seed_in = seed_b;
      reseed_req = 1'b1;
      step();
      reseed_req = 1'b0;
      chk("warm_reseed_seed", core_seedloop, seed_b);
      bc = 1;
      rh = 1;
      for (int c = 0; c < 14; c++) begin
         step();
         if (reseed_busy) bc++;
         if (core_rst) rh++;
      end
      chk("warm_busy_cycles", 64'(bc), 64'd10);
      chk("warm_rst_cycles", 64'(rh), 64'd2);

      // rst together with reseed: default seed wins
      rst = 1'b1;
      reseed_req = 1'b1;
      seed_in = {$urandom, $urandom};
      step();
      chk("rst_beats_reseed", core_seedloop, SD);
      rst = 1'b0;
      reseed_req = 1'b0;

      // randomized traffic with sporadic reseeds and resets
      for (int c = 0; c < 400; c++) begin
         req = N'($urandom_range(0, 15));
         reseed_req = ($urandom_range(0, 39) == 0);
         seed_in = {$urandom, $urandom};
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      reseed_req = 1'b0;

      // rst while serving with requests pending
      req = 4'b1111;
      for (int c = 0; c < 30; c++) begin
         if (!reseed_busy) break;
         step();
      end
      chk("serve_reached", 64'(reseed_busy), 64'd0);
      repeat (2) step();
      rst = 1'b1;
      step();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_count", 64'(served_count), 64'd0);
      chk("rst_seed", core_seedloop, SD);
      chk("rst_core_rst", 64'(core_rst), 64'd1);
      rst = 1'b0;
      req = '0;
      repeat (2) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
